// File: rtl/ranging_sequencer_if.sv
// Handshake bundle between the ranging sequencer and its host: run control, raw
// echo in, trigger out and the distance/valid/timeout result.
interface ranging_sequencer_if #(
    parameter int DIST_W = 16
);
    logic              enable;
    logic              echo;
    logic              trig;
    logic [DIST_W-1:0] distance;
    logic              dist_valid;
    logic              timeout;
    logic              busy;

    modport master (
        output enable, echo,
        input  trig, distance, dist_valid, timeout, busy
    );

    modport slave (
        input  enable, echo,
        output trig, distance, dist_valid, timeout, busy
    );
endinterface

// File: rtl/ranging_sequencer.sv
// Ultrasonic ranging controller: trigger pulse, echo wait, echo timing in whole
// centimetres, then hold-off until the next fixed measurement slot.
module ranging_sequencer #(
    parameter int TRIG_CYCLES         = 500,
    parameter int ECHO_TIMEOUT_CYCLES = 1500000,
    parameter int PERIOD_CYCLES       = 3000000,
    parameter int CYCLES_PER_CM       = 2900,
    parameter int DIST_W              = 16
) (
    input logic                clock,
    input logic                resetn,
    ranging_sequencer_if.slave bus
);
    localparam int TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam int TO_W   = (ECHO_TIMEOUT_CYCLES > 1) ? $clog2(ECHO_TIMEOUT_CYCLES) : 1;
    localparam int PER_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int SUB_W  = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [DIST_W-1:0] CM_MAX    = '1;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t              state_reg;
    logic                echo_m_reg;
    logic                echo_s_reg;
    logic                echo_d_reg;
    logic [TRIG_W-1:0]   trig_cnt_reg;
    logic [TO_W-1:0]     timeout_cnt_reg;
    logic [PER_W-1:0]    period_cnt_reg;
    logic [SUB_W-1:0]    sub_cnt_reg;
    logic [DIST_W-1:0]   cm_cnt_reg;
    logic                trig_reg;
    logic [DIST_W-1:0]   distance_reg;
    logic                dist_valid_reg;
    logic                timeout_reg;
    logic                busy_reg;

    logic echo_rise;
    logic echo_fall;

    assign echo_rise = echo_s_reg & ~echo_d_reg;
    assign echo_fall = ~echo_s_reg & echo_d_reg;

    assign bus.trig       = trig_reg;
    assign bus.distance   = distance_reg;
    assign bus.dist_valid = dist_valid_reg;
    assign bus.timeout    = timeout_reg;
    assign bus.busy       = busy_reg;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            echo_m_reg      <= 1'b0;
            echo_s_reg      <= 1'b0;
            echo_d_reg      <= 1'b0;
            trig_cnt_reg    <= '0;
            timeout_cnt_reg <= '0;
            period_cnt_reg  <= '0;
            sub_cnt_reg     <= '0;
            cm_cnt_reg      <= '0;
            trig_reg        <= 1'b0;
            distance_reg    <= '0;
            dist_valid_reg  <= 1'b0;
            timeout_reg     <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            echo_m_reg     <= bus.echo;
            echo_s_reg     <= echo_m_reg;
            echo_d_reg     <= echo_s_reg;
            dist_valid_reg <= 1'b0;
            timeout_reg    <= 1'b0;

            // Slot timer runs from trigger entry; later assignments below restart it.
            if (state_reg != IDLE && period_cnt_reg != PER_LAST) begin
                period_cnt_reg <= period_cnt_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.enable) begin
                        state_reg      <= TRIG;
                        trig_reg       <= 1'b1;
                        trig_cnt_reg   <= '0;
                        period_cnt_reg <= '0;
                        busy_reg       <= 1'b1;
                    end
                end
                TRIG: begin
                    if (trig_cnt_reg == TRIG_LAST) begin
                        state_reg       <= WAIT_RISE;
                        trig_reg        <= 1'b0;
                        timeout_cnt_reg <= '0;
                    end else begin
                        trig_cnt_reg <= trig_cnt_reg + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (timeout_cnt_reg == TO_LAST) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= HOLDOFF;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                        if (echo_rise) begin
                            // The rise cycle already has echo_s high, so it counts.
                            state_reg   <= MEASURE;
                            sub_cnt_reg <= SUB_W'(1);
                            cm_cnt_reg  <= '0;
                        end
                    end
                end
                MEASURE: begin
                    if (echo_fall) begin
                        distance_reg   <= cm_cnt_reg;
                        dist_valid_reg <= 1'b1;
                        state_reg      <= HOLDOFF;
                    end else if (timeout_cnt_reg == TO_LAST) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= HOLDOFF;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                        if (echo_s_reg) begin
                            if (sub_cnt_reg == SUB_LAST) begin
                                sub_cnt_reg <= '0;
                                if (cm_cnt_reg != CM_MAX) begin
                                    cm_cnt_reg <= cm_cnt_reg + 1'b1;
                                end
                            end else begin
                                sub_cnt_reg <= sub_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                HOLDOFF: begin
                    // A stuck-high echo keeps us here so the sensor is never retriggered mid-echo.
                    if (period_cnt_reg == PER_LAST && !echo_s_reg) begin
                        if (bus.enable) begin
                            state_reg      <= TRIG;
                            trig_reg       <= 1'b1;
                            trig_cnt_reg   <= '0;
                            period_cnt_reg <= '0;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    trig_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ranging_sequencer.sv
// Randomized bench for ranging_sequencer: echo timing is driven relative to trigger
// fall and results are predicted from the measurement rules with plain arithmetic.
module tb_ranging_sequencer;
    localparam int TRIG   = 5;
    localparam int ETO    = 100;
    localparam int PERIOD = 300;
    localparam int CPC    = 4;
    localparam int DW     = 4;
    localparam int DMAX   = (1 << DW) - 1;

    logic clock;
    logic resetn;

    ranging_sequencer_if #(.DIST_W(DW)) bus ();

    ranging_sequencer #(
        .TRIG_CYCLES(TRIG),
        .ECHO_TIMEOUT_CYCLES(ETO),
        .PERIOD_CYCLES(PERIOD),
        .CYCLES_PER_CM(CPC),
        .DIST_W(DW)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rise = 0;
    int n_rises = 0;
    int n_valid = 0;
    int n_timeout = 0;
    int last_valid = 0;
    int last_timeout = 0;
    int bad_overlap = 0;
    int bad_consec = 0;
    int echo_low_cyc = 0;
    int model_dist = 0;
    bit trig_prev = 1'b0;
    bit pulse_prev = 1'b0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Advance to the next falling edge and record what the DUT did on the last rising edge.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (bus.trig && !trig_prev) begin
            last_rise = cyc;
            n_rises++;
        end
        if (bus.dist_valid) begin
            n_valid++;
            last_valid = cyc;
        end
        if (bus.timeout) begin
            n_timeout++;
            last_timeout = cyc;
        end
        if (bus.dist_valid && bus.timeout) bad_overlap++;
        if ((bus.dist_valid || bus.timeout) && pulse_prev) bad_consec++;
        pulse_prev = bus.dist_valid || bus.timeout;
        trig_prev  = bus.trig;
    endtask

    task automatic wait_rise_ev(output bit ok);
        int r0;
        int g;
        r0 = n_rises;
        g = 0;
        while (n_rises == r0 && g < 2000) begin
            tick();
            g++;
        end
        ok = (n_rises != r0);
    endtask

    task automatic trig_fall_check();
        int g;
        g = 0;
        while (bus.trig && g < 100) begin
            tick();
            g++;
        end
        check_eq("trig_fell", bus.trig, 0);
        check_eq("trig_width", cyc - last_rise, TRIG);
    endtask

    task automatic next_rise_check();
        int exp_rise;
        bit ok;
        exp_rise = imax(last_rise + PERIOD, echo_low_cyc + 3);
        wait_rise_ev(ok);
        check_eq("rise_seen", ok, 1);
        check_eq("rise_cyc", last_rise, exp_rise);
    endtask

    // Called at the falling edge where trig was first seen low; d cycles later echo
    // goes high for n cycles (n=0: no echo). pre: echo already high, drop it after d.
    task automatic measure(input int d, input int n, input bit drop_en, input bit pre);
        int t0, v0, to0, g, exp_cyc, exp_d;
        bit exp_v;
        t0  = cyc;
        v0  = n_valid;
        to0 = n_timeout;
        exp_v   = !pre && (n > 0) && (d + n + 3 <= ETO);
        exp_cyc = exp_v ? t0 + d + n + 3 : t0 + ETO;
        exp_d   = exp_v ? ((n / CPC > DMAX) ? DMAX : n / CPC) : model_dist;
        repeat (d) tick();
        if (pre) begin
            bus.echo = 1'b0;
        end else if (n > 0) begin
            bus.echo = 1'b1;
            if (drop_en) begin
                repeat (n / 2) tick();
                bus.enable = 1'b0;
                repeat (n - n / 2) tick();
            end else begin
                repeat (n) tick();
            end
            bus.echo = 1'b0;
        end
        echo_low_cyc = cyc;
        g = 0;
        while (n_valid == v0 && n_timeout == to0 && g < 400) begin
            tick();
            g++;
        end
        check_eq("valid_count", n_valid - v0, exp_v ? 1 : 0);
        check_eq("timeout_count", n_timeout - to0, exp_v ? 0 : 1);
        check_eq("pulse_cyc", exp_v ? last_valid : last_timeout, exp_cyc);
        check_eq("distance", bus.distance, exp_d);
        check_eq("busy_meas", bus.busy, 1);
        model_dist = exp_d;
        $display("meas d=%0d n=%0d pre=%0d -> %s distance=%0d", d, n, pre,
                 exp_v ? "valid" : "timeout", bus.distance);
    endtask

    task automatic do_meas(input int d, input int n);
        measure(d, n, 1'b0, 1'b0);
        next_rise_check();
        trig_fall_check();
    endtask

    initial begin
        bit ok;
        int k, r0, v0, to0;

        resetn = 1'b0;
        bus.enable = 1'b0;
        bus.echo = 1'b0;
        repeat (3) tick();
        check_eq("rst_trig", bus.trig, 0);
        check_eq("rst_distance", bus.distance, 0);
        check_eq("rst_valid", bus.dist_valid, 0);
        check_eq("rst_timeout", bus.timeout, 0);
        check_eq("rst_busy", bus.busy, 0);

        bus.enable = 1'b1;
        resetn = 1'b1;
        wait_rise_ev(ok);
        check_eq("first_rise_seen", ok, 1);
        trig_fall_check();

        do_meas(10, 41);
        do_meas(3, 15);
        do_meas(3, 80);
        do_meas(2, 28);
        do_meas(0, 0);
        do_meas(10, 87);
        do_meas(10, 88);
        for (int i = 0; i < 12; i++) begin
            do_meas(int'($urandom_range(15, 0)), int'($urandom_range(100, 0)));
        end

        // Echo already high when the trigger ends: must not start a measurement.
        measure(0, 0, 1'b0, 1'b0);
        wait_rise_ev(ok);
        check_eq("pre_rise_seen", ok, 1);
        bus.echo = 1'b1;
        trig_fall_check();
        measure(20, 0, 1'b0, 1'b1);
        next_rise_check();
        trig_fall_check();

        // Echo stuck high past the end of the slot.
        do_meas(5, 400);

        // Enable dropped mid-measurement: cycle completes, then sequencer idles.
        measure(5, 40, 1'b1, 1'b0);
        r0 = n_rises;
        while (cyc < last_rise + PERIOD + 10) tick();
        check_eq("idle_no_trig", n_rises - r0, 0);
        check_eq("idle_busy", bus.busy, 0);
        bus.enable = 1'b1;
        k = cyc;
        tick();
        check_eq("rearm_rise", last_rise, k + 1);
        trig_fall_check();
        do_meas(4, 30);

        // Reset in the middle of an echo.
        repeat (3) tick();
        bus.echo = 1'b1;
        repeat (20) tick();
        v0 = n_valid;
        to0 = n_timeout;
        resetn = 1'b0;
        tick();
        check_eq("mid_rst_trig", bus.trig, 0);
        check_eq("mid_rst_distance", bus.distance, 0);
        check_eq("mid_rst_busy", bus.busy, 0);
        bus.echo = 1'b0;
        resetn = 1'b1;
        model_dist = 0;
        echo_low_cyc = cyc;
        k = cyc;
        wait_rise_ev(ok);
        check_eq("rst_rise_seen", ok, 1);
        check_eq("rst_rise_cyc", last_rise, k + 1);
        check_eq("rst_no_pulse", (n_valid - v0) + (n_timeout - to0), 0);
        trig_fall_check();
        do_meas(6, 33);

        check_eq("pulse_overlap", bad_overlap, 0);
        check_eq("pulse_consecutive", bad_consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
